mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Unified-memory arbiter for the 5-stage 16-bit pipeline. Shares a single-port, fixed-latency memory between the instruction-fetch port (read-only) and the data-access port (read/write). Generates the pipeline-wide stall while any request is outstanding. Sits between the IF/MEM stages and the backing memory.

## Interface
- LATENCY, 2: memory access cycles, must be ≥1. mem_en is held for this many cycles per access.
- AW, 16: address width.
- DW, 16: data width.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_rd  in  1  data read request; level, held until d_ready.
- d_wr  in  1  data write request; level, held until d_ready.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- stall  out  1  freeze pipeline.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the final access cycle.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise grant one requester: latch its address, its write data and the we flag into mem_* registers, set cnt=LATENCY-1, and go to BUSY.
- BUSY:
  - mem_en=1; mem_we=1 for a data write only.
  - Decrement cnt each cycle. At cnt=0, capture mem_rdata into the granted port's rdata register and go to DONE.
- DONE:
  - Pulse the granted port's ready for exactly one cycle. mem_en=0.
  - In the same cycle, arbitrate the next request. The requester just served is ignored this cycle, because its request is still asserted.
  - On a grant go to BUSY; otherwise go to IDLE.
- Arbitration rules:
  - Data beats fetch by default.
  - A fairness bit is set when fetch was pending but lost. While it is set, fetch wins the next grant; the bit clears on a fetch grant.
  - With both ports continuously requesting, grants therefore alternate D, I, D, I…
- If d_rd and d_wr are both asserted, the access is a write.
- Writes still pulse d_ready. d_rdata holds its previous value on a write.
- Address and data are latched at grant. Input changes during BUSY have no effect.
- stall = (if_req & ~if_ready) | ((d_rd|d_wr) & ~d_ready), combinational. stall is forced to 0 while rst_n=0.
- Reset mid-access:
  - State returns to IDLE and cnt=0.
  - mem_en, mem_we, if_ready and d_ready go to 0; the fairness bit goes to 0.
  - The in-flight access is abandoned, with no ready pulse.
  - Requests still asserted after reset are re-arbitrated from IDLE.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, stall=0.
- Isolated request first seen in IDLE at cycle t:
  - mem_en is high in cycles t+1 through t+LATENCY.
  - ready is high in cycle t+LATENCY+1.
- Back-to-back requests: the next access starts the cycle after DONE, with no IDLE bubble. Throughput is one access per LATENCY+1 cycles.
- Memory outputs are registered. No combinational path runs from requests to mem_*.
- With LATENCY=1, BUSY lasts one cycle.

## Structure
- Shared package (cpu_pkg) holds:
  - the arb_state_t enum {IDLE, BUSY, DONE};
  - the grant_t enum {GNT_I, GNT_D};
  - the default LATENCY constant.
- One natural sub-module, mem_lat_counter: a loadable down-counter with a zero flag, width $clog2(LATENCY)+1.
- Everything else is in mem_arbiter.

## Test plan
Benches run with LATENCY=2.
1. Isolated fetch: if_req=1 with if_addr=0x0010 at cycle 0, mem_rdata=0xA5A5 at cycle 2 → mem_en high in cycles 1–2 with mem_addr=0x0010; if_ready=1 with if_rdata=0xA5A5 at cycle 3; stall=1 in cycles 0–2 and 0 at cycle 3.
2. Simultaneous requests: if_req=1 and d_rd=1 (d_addr=0x0200) at cycle 0 → data is granted first and d_ready pulses at cycle 3; fetch is granted from DONE, mem_en is high in cycles 4–5, and if_ready pulses at cycle 6.
3. Both ports requesting continuously for 20 cycles → grant sequence D, I, D, I…; no port waits more than 2×(LATENCY+1) cycles.
4. Write d_wr=1, d_addr=0x0040, d_wdata=0xBEEF → mem_we=1 and mem_wdata=0xBEEF in cycles 1–2; d_ready pulses at cycle 3; d_rdata unchanged.
5. d_rd=1 and d_wr=1 together → mem_we=1, treated as a write.
6. rst_n=0 during cycle 2 of a fetch → the next cycle has mem_en=0 and no if_ready; after release with if_req held, the fetch restarts and if_ready pulses LATENCY+1 cycles after the first IDLE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline's memory-side blocks: arbiter FSM
// encoding, grant identifiers and the default memory latency.
package cpu_pkg;

    localparam int ARB_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times one memory access; zero marks the final
// access cycle.
module mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: shares one fixed-latency memory between the fetch
// port and the data port, and raises the pipeline stall while either waits.
//
// Handshake: each port holds its request level until a one-cycle ready pulse;
// rdata is valid only in that ready cycle. Address/data are latched at grant.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int LATENCY = ARB_LATENCY,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    arb_state_t    state;
    grant_t        grant;
    logic          fair;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    logic d_req;
    logic served_i, served_d;
    logic i_elig, d_elig;
    logic can_arb;
    logic pick_i, pick_d;
    logic do_grant;

    assign d_req = d_rd | d_wr;

    // The port served in DONE still holds its request this cycle; skip it.
    always_comb begin
        served_i = (state == DONE) && (grant == GNT_I);
        served_d = (state == DONE) && (grant == GNT_D);
        i_elig   = if_req & ~served_i;
        d_elig   = d_req & ~served_d;
        can_arb  = (state == IDLE) || (state == DONE);
        pick_i   = i_elig & (fair | ~d_elig);
        pick_d   = d_elig & ~pick_i;
        do_grant = can_arb & (pick_i | pick_d);
    end

    mem_lat_counter #(
        .W (CW)
    ) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (do_grant),
        .load_val (CNT_LOAD),
        .dec      (state == BUSY),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= GNT_I;
            fair      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (do_grant) begin
                        state  <= BUSY;
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            grant     <= GNT_D;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_wr;
                            // A fetch that was eligible but lost gets the next grant.
                            fair      <= fair | i_elig;
                        end else begin
                            grant    <= GNT_I;
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                            fair     <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (grant == GNT_I) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall = rst_n & ((if_req & ~if_ready) | (d_req & ~d_ready));

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LATENCY=2): readies are scored against
// expected grant order and read data queued when each request is driven.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int LAT = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  dbg_state;

    mem_arbiter #(
        .LATENCY (LAT),
        .AW      (16),
        .DW      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .stall     (stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // memory model: fixed contents per address
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5A5 : ((a ^ 16'hC3C3) + 16'h0101);
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    // scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_i_q[$];
    logic [15:0] exp_d_q[$];
    logic        exp_gnt_q[$];
    logic [15:0] last_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (if_ready) begin
            check("if_ready_expected", 32'(exp_i_q.size() != 0 && exp_gnt_q.size() != 0), 32'd1);
            if (exp_i_q.size() != 0 && exp_gnt_q.size() != 0) begin
                check("grant_order_i", 32'(GNT_I), 32'(exp_gnt_q.pop_front()));
                check("if_rdata", 32'(if_rdata), 32'(exp_i_q.pop_front()));
            end
        end
        if (d_ready) begin
            check("d_ready_expected", 32'(exp_d_q.size() != 0 && exp_gnt_q.size() != 0), 32'd1);
            if (exp_d_q.size() != 0 && exp_gnt_q.size() != 0) begin
                check("grant_order_d", 32'(GNT_D), 32'(exp_gnt_q.pop_front()));
                check("d_rdata", 32'(d_rdata), 32'(exp_d_q.pop_front()));
            end
        end
    end

    initial begin
        int last_i_c, last_d_c, ni, nd;

        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0000;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        last_d  = 16'h0000;

        // reset values, stall forced low while a request is held in reset
        repeat (3) mid();
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        if_req = 1'b0;
        rst_n  = 1'b1;
        mid();

        // isolated fetch
        mid();
        if_req  = 1'b1;
        if_addr = 16'h0010;
        exp_gnt_q.push_back(GNT_I);
        exp_i_q.push_back(16'hA5A5);
        #1;
        check("t1_c0_stall", 32'(stall), 32'd1);
        check("t1_c0_mem_en", 32'(mem_en), 32'd0);
        mid(); #1;
        check("t1_c1_mem_en", 32'(mem_en), 32'd1);
        check("t1_c1_mem_addr", 32'(mem_addr), 32'h0010);
        check("t1_c1_mem_we", 32'(mem_we), 32'd0);
        check("t1_c1_state", 32'(dbg_state), 32'(BUSY));
        check("t1_c1_stall", 32'(stall), 32'd1);
        mid(); #1;
        check("t1_c2_mem_en", 32'(mem_en), 32'd1);
        check("t1_c2_if_ready", 32'(if_ready), 32'd0);
        check("t1_c2_stall", 32'(stall), 32'd1);
        mid(); #1;
        check("t1_c3_if_ready", 32'(if_ready), 32'd1);
        check("t1_c3_if_rdata", 32'(if_rdata), 32'hA5A5);
        check("t1_c3_mem_en", 32'(mem_en), 32'd0);
        check("t1_c3_stall", 32'(stall), 32'd0);
        if_req = 1'b0;
        mid();

        // simultaneous requests: data first, fetch from DONE
        mid();
        if_req  = 1'b1;
        if_addr = 16'h0020;
        d_rd    = 1'b1;
        d_addr  = 16'h0200;
        exp_gnt_q.push_back(GNT_D);
        exp_gnt_q.push_back(GNT_I);
        exp_d_q.push_back(mem_model(16'h0200));
        exp_i_q.push_back(mem_model(16'h0020));
        last_d = mem_model(16'h0200);
        #1;
        check("t2_c0_stall", 32'(stall), 32'd1);
        mid(); #1;
        check("t2_c1_mem_addr", 32'(mem_addr), 32'h0200);
        check("t2_c1_mem_en", 32'(mem_en), 32'd1);
        mid();
        mid(); #1;
        check("t2_c3_d_ready", 32'(d_ready), 32'd1);
        check("t2_c3_if_ready", 32'(if_ready), 32'd0);
        check("t2_c3_mem_en", 32'(mem_en), 32'd0);
        check("t2_c3_stall", 32'(stall), 32'd1);
        d_rd = 1'b0;
        mid(); #1;
        check("t2_c4_mem_en", 32'(mem_en), 32'd1);
        check("t2_c4_mem_addr", 32'(mem_addr), 32'h0020);
        mid(); #1;
        check("t2_c5_mem_en", 32'(mem_en), 32'd1);
        mid(); #1;
        check("t2_c6_if_ready", 32'(if_ready), 32'd1);
        check("t2_c6_stall", 32'(stall), 32'd0);
        if_req = 1'b0;
        mid();

        // continuous requests on both ports: D, I, D, I, D, I
        last_i_c = 0;
        last_d_c = 0;
        ni = 0;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            exp_gnt_q.push_back(GNT_D);
            exp_gnt_q.push_back(GNT_I);
            exp_d_q.push_back(mem_model(16'h0300));
            exp_i_q.push_back(mem_model(16'h0030));
        end
        last_d = mem_model(16'h0300);
        for (int c = 0; c < 19; c++) begin
            mid();
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 16'h0030;
                d_rd    = 1'b1;
                d_addr  = 16'h0300;
            end
            #1;
            if (d_ready) begin
                check("t3_d_wait", 32'((c - last_d_c) <= 2 * (LAT + 1)), 32'd1);
                last_d_c = c;
                nd++;
            end
            if (if_ready) begin
                check("t3_i_wait", 32'((c - last_i_c) <= 2 * (LAT + 1)), 32'd1);
                last_i_c = c;
                ni++;
            end
            if (c == 18) begin
                if_req = 1'b0;
                d_rd   = 1'b0;
            end
        end
        check("t3_d_count", 32'(nd), 32'd3);
        check("t3_i_count", 32'(ni), 32'd3);
        mid();

        // write
        mid();
        d_wr    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'hBEEF;
        exp_gnt_q.push_back(GNT_D);
        exp_d_q.push_back(last_d);
        mid(); #1;
        check("t4_c1_mem_we", 32'(mem_we), 32'd1);
        check("t4_c1_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("t4_c1_mem_addr", 32'(mem_addr), 32'h0040);
        mid(); #1;
        check("t4_c2_mem_we", 32'(mem_we), 32'd1);
        check("t4_c2_mem_en", 32'(mem_en), 32'd1);
        mid(); #1;
        check("t4_c3_d_ready", 32'(d_ready), 32'd1);
        check("t4_c3_mem_we", 32'(mem_we), 32'd0);
        d_wr = 1'b0;
        mid();

        // read and write together is a write
        mid();
        d_rd    = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0044;
        d_wdata = 16'h1234;
        exp_gnt_q.push_back(GNT_D);
        exp_d_q.push_back(last_d);
        mid(); #1;
        check("t5_c1_mem_we", 32'(mem_we), 32'd1);
        check("t5_c1_mem_wdata", 32'(mem_wdata), 32'h1234);
        mid();
        mid(); #1;
        check("t5_c3_d_ready", 32'(d_ready), 32'd1);
        d_rd = 1'b0;
        d_wr = 1'b0;
        mid();

        // reset during an in-flight fetch, then restart
        mid();
        if_req  = 1'b1;
        if_addr = 16'h0050;
        mid(); #1;
        check("t6_c1_mem_en", 32'(mem_en), 32'd1);
        mid();
        rst_n = 1'b0;
        #1;
        check("t6_c2_stall_rst", 32'(stall), 32'd0);
        mid(); #1;
        check("t6_c3_mem_en", 32'(mem_en), 32'd0);
        check("t6_c3_if_ready", 32'(if_ready), 32'd0);
        check("t6_c3_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        exp_gnt_q.push_back(GNT_I);
        exp_i_q.push_back(mem_model(16'h0050));
        mid(); #1;
        check("t6_c4_mem_en", 32'(mem_en), 32'd1);
        check("t6_c4_mem_addr", 32'(mem_addr), 32'h0050);
        mid(); #1;
        check("t6_c5_if_ready", 32'(if_ready), 32'd0);
        mid(); #1;
        check("t6_c6_if_ready", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        mid();
        mid(); #3;

        check("queues_drained", 32'(exp_gnt_q.size() + exp_i_q.size() + exp_d_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
